// File: rtl/bb_scrambler_par.sv
// Word-parallel BB scrambler: XORs W bits per cycle with a Fibonacci LFSR PRBS,
// reseeds at frame boundaries. Optional bypass port under `BB_SCMB_BYPASS_EN.
module bb_scrambler_par #(
   parameter int W        = 8,
   parameter int LFSR_LEN = 15,
   parameter int TAP_A    = 14,
   parameter int TAP_B    = 15,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [LFSR_LEN:1]   initial_state,
   input  logic [CNT_W-1:0]    frame_len,
   input  logic                load,
   input  logic                in_valid,
   input  logic [W-1:0]        in_data,
`ifdef BB_SCMB_BYPASS_EN
   input  logic                bypass,
`endif
   output logic                in_ready,
   output logic                out_valid,
   output logic [W-1:0]        out_data,
   input  logic                out_ready,
   output logic                out_sof
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [LFSR_LEN:1] lfsr_q, lfsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              first_pending_q, first_pending_d;
   logic              out_valid_q, out_valid_d;
   logic [W-1:0]      out_data_q, out_data_d;
   logic              out_sof_q, out_sof_d;

   logic              accept;
   logic              seed_use;
   logic              byp;
   logic [W-1:0]      scr_data;
   logic [LFSR_LEN:1] lfsr_next;
   logic [CNT_W-1:0]  cnt_base;

`ifdef BB_SCMB_BYPASS_EN
   assign byp = bypass;
`else
   assign byp = 1'b0;
`endif

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign seed_use = first_pending_q || load;

   // Unrolled serial LFSR: the MSB of the word is the first bit in time.
   always_comb begin : scramble
      logic [LFSR_LEN:1] s;
      logic              fb;
      // NOTE: blocking assignments here are intentional; s carries the state
      // from one unrolled bit step to the next within the same cycle.
      s        = seed_use ? initial_state : lfsr_q;
      fb       = 1'b0;
      scr_data = '0;
      for (int i = W - 1; i >= 0; i--) begin
         fb          = s[TAP_A] ^ s[TAP_B];
         scr_data[i] = in_data[i] ^ fb;
         s           = {s[LFSR_LEN-1:1], fb};
      end
      lfsr_next = s;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch
      // is inferred on paths that leave a signal untouched.
      lfsr_d          = lfsr_q;
      cnt_d           = cnt_q;
      first_pending_d = first_pending_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_sof_d       = out_sof_q;
      cnt_base        = load ? '0 : cnt_q;

      if (load) begin
         first_pending_d = 1'b1;
         cnt_d           = '0;
      end

      if (accept) begin
         out_valid_d = 1'b1;
         if (byp) begin
            out_data_d = in_data;
            out_sof_d  = 1'b0;
         end else begin
            out_data_d = scr_data;
            out_sof_d  = seed_use;
            lfsr_d     = lfsr_next;
            // Equality compare only: a frame_len below the count lets it wrap.
            if ((frame_len != '0) && (cnt_base == frame_len - CNT_ONE)) begin
               cnt_d           = '0;
               first_pending_d = 1'b1;
            end else begin
               cnt_d           = cnt_base + CNT_ONE;
               first_pending_d = 1'b0;
            end
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q          <= '0;
         cnt_q           <= '0;
         first_pending_q <= 1'b1;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_sof_q       <= 1'b0;
      end else begin
         lfsr_q          <= lfsr_d;
         cnt_q           <= cnt_d;
         first_pending_q <= first_pending_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_sof_q       <= out_sof_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_bb_scrambler_par.sv
// Directed bench for bb_scrambler_par (W=8, DVB-S2 polynomial); a second
// instance descrambles a random stream to confirm the involution property.
module tb_bb_scrambler_par;

   localparam int W = 8;
   localparam int L = 15;
   localparam int C = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [L:1]    seed;
   logic [C-1:0]  frame_len;
   logic          load;
   logic          in_valid, in_valid2;
   logic [W-1:0]  in_data, in_data2;
   logic          in_ready, in_ready2;
   logic          out_valid, out_valid2;
   logic [W-1:0]  out_data, out_data2;
   logic          out_ready;
   logic          out_sof, out_sof2;

   int            n_vec  = 0;
   int            n_miss = 0;
   logic [L:1]    m_state;
   logic [W-1:0]  orig [64];
   logic [W-1:0]  scr  [64];
   logic [W-1:0]  exp_b;

   always #5 clk = ~clk;

   bb_scrambler_par #(.W(W), .LFSR_LEN(L), .TAP_A(14), .TAP_B(15), .CNT_W(C)) dut (
      .clk(clk), .reset_n(reset_n), .initial_state(seed), .frame_len(frame_len),
      .load(load), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_sof(out_sof)
   );

   bb_scrambler_par #(.W(W), .LFSR_LEN(L), .TAP_A(14), .TAP_B(15), .CNT_W(C)) dut2 (
      .clk(clk), .reset_n(reset_n), .initial_state(seed), .frame_len(frame_len),
      .load(load), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
      .out_valid(out_valid2), .out_data(out_data2), .out_ready(1'b1), .out_sof(out_sof2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic expect_word(input string tag, input logic [W-1:0] d, input logic sof);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"},  64'(out_data),  64'(d));
      check({tag, "_sof"},   64'(out_sof),   64'(sof));
   endtask

   task automatic pulse_load();
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   // Serial reference: one LFSR step per bit, MSB first.
   task automatic model_byte(input logic [W-1:0] d, output logic [W-1:0] o);
      logic fb;
      o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         fb      = m_state[14] ^ m_state[15];
         o[i]    = d[i] ^ fb;
         m_state = {m_state[L-1:1], fb};
      end
   endtask

   initial begin
      // s15..s1 = 000000010101001  (s1..s15 = 100101010000000)
      seed      = 15'h00A9;
      reset_n   = 1'b0;
      frame_len = '0;
      load      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_valid2 = 1'b0;
      in_data2  = '0;
      out_ready = 1'b1;

      #3;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data",  64'(out_data),  64'd0);
      check("rst_sof",   64'(out_sof),   64'd0);
      check("rst_ready", 64'(in_ready),  64'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // DVB-S2 vector, seeded from reset without any load
      send(8'h00); expect_word("dvb0", 8'h03, 1'b1);
      send(8'h00); expect_word("dvb1", 8'hF6, 1'b0);
      send(8'h00); expect_word("dvb2", 8'h08, 1'b0);
      @(posedge clk); #1;
      check("idle_valid", 64'(out_valid), 64'd0);

      // Load collision on the second accepted word
      pulse_load();
      send(8'h00); expect_word("ld0", 8'h03, 1'b1);
      load = 1'b1;
      send(8'h00); expect_word("ld1", 8'h03, 1'b1);
      load = 1'b0;
      send(8'h00); expect_word("ld2", 8'hF6, 1'b0);

      // Frame reseed every 3 words
      frame_len = 16'd3;
      pulse_load();
      send(8'h00); expect_word("fr0", 8'h03, 1'b1);
      send(8'h00); expect_word("fr1", 8'hF6, 1'b0);
      send(8'h00); expect_word("fr2", 8'h08, 1'b0);
      send(8'h00); expect_word("fr3", 8'h03, 1'b1);
      send(8'h00); expect_word("fr4", 8'hF6, 1'b0);
      send(8'h00); expect_word("fr5", 8'h08, 1'b0);

      // frame_len = 1: every word restarts from the seed
      frame_len = 16'd1;
      send(8'h00); expect_word("f1_0", 8'h03, 1'b1);
      send(8'h00); expect_word("f1_1", 8'h03, 1'b1);
      frame_len = '0;

      // Backpressure: out_ready 1,0,0,1 under continuous in_valid
      pulse_load();
      in_valid = 1'b1;
      in_data  = 8'h11;
      @(posedge clk); #1;
      expect_word("bp0", 8'h12, 1'b1);
      in_data   = 8'h22;
      out_ready = 1'b0;
      #1;
      check("bp_stall_a", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("bp_stall_b", 64'(in_ready), 64'd0);
      expect_word("bp_hold", 8'h12, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      #1;
      check("bp_release", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      expect_word("bp1", 8'hD4, 1'b0);
      in_data = 8'h33;
      @(posedge clk); #1;
      expect_word("bp2", 8'h3B, 1'b0);
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk); #1;
      check("bp_drain", 64'(out_valid), 64'd0);

      // Mid-run reset while out_valid is held
      pulse_load();
      send(8'h00);
      out_ready = 1'b0;
      expect_word("mr0", 8'h03, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check("mr_valid", 64'(out_valid), 64'd0);
      check("mr_data",  64'(out_data),  64'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      send(8'h00); expect_word("mr1", 8'h03, 1'b1);
      send(8'h00); expect_word("mr2", 8'hF6, 1'b0);

      // Involution: scramble 64 random words, then descramble in dut2
      pulse_load();
      m_state = seed;
      for (int i = 0; i < 64; i++) begin
         orig[i] = W'($urandom);
         model_byte(orig[i], exp_b);
         send(orig[i]);
         check("rnd_scr", 64'(out_data), 64'(exp_b));
         scr[i] = out_data;
      end
      @(posedge clk); #1;
      for (int i = 0; i < 64; i++) begin
         in_valid2 = 1'b1;
         in_data2  = scr[i];
         @(posedge clk); #1;
         in_valid2 = 1'b0;
         check("inv_data", 64'(out_data2), 64'(orig[i]));
         check("inv_sof",  64'(out_sof2),  64'(i == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
